// File: rtl/store_write_buffer.sv
// store_write_buffer
//
// Store queue between the MEM-stage store-data formatter and the data-memory
// write port. Each legal, aligned store is lane-aligned onto the 32-bit bus,
// given byte strobes, and queued in a DEPTH-entry FIFO. The FIFO head is
// presented to memory over a valid/ready handshake.
//
// Ports:
//   clk, reset        rising-edge clock; synchronous active-high reset
//   StoreValid        store present in MEM this cycle
//   StoreAddr[31:0]   byte address of the store
//   StoreData[31:0]   zero-extended store data
//   StoreControl[2:0] 000 sb, 001 sh, 010 sw; other codes ignored
//   LoadValid         load present in MEM this cycle
//   LoadAddr[31:0]    byte address of the load
//   StallStore        queue full; store must be held in MEM
//   StallLoad         load word matches a pending store; hold in MEM
//   MisalignedStore   store rejected as misaligned (not queued)
//   MemWValid         head entry presented to memory
//   MemWAddr[31:0]    word address of head entry, [1:0] = 00
//   MemWData[31:0]    lane-aligned head data
//   MemWStrb[3:0]     byte enables, bit i covers lane [8i+7:8i]
//   MemWReady         memory accepts the head entry
//   Empty             no pending entries
module store_write_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StoreValid,
    input  logic [31:0] StoreAddr,
    input  logic [31:0] StoreData,
    input  logic [2:0]  StoreControl,
    input  logic        LoadValid,
    input  logic [31:0] LoadAddr,
    output logic        StallStore,
    output logic        StallLoad,
    output logic        MisalignedStore,
    output logic        MemWValid,
    output logic [31:0] MemWAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemWStrb,
    input  logic        MemWReady,
    output logic        Empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        CTRL_SB = 3'b000,
        CTRL_SH = 3'b001,
        CTRL_SW = 3'b010
    } store_ctrl_e;

    // Entry storage: only the word address is kept; [1:0] is always 00.
    logic [29:0] waddr_q [DEPTH];
    logic [29:0] waddr_d [DEPTH];
    logic [31:0] wdata_q [DEPTH];
    logic [31:0] wdata_d [DEPTH];
    logic [3:0]  wstrb_q [DEPTH];
    logic [3:0]  wstrb_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;

    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    cnt_t count_q, count_d;

    logic        legal_code;
    logic        aligned;
    logic        full;
    logic        enq;
    logic        deq;
    logic [31:0] fmt_data;
    logic [3:0]  fmt_strb;
    logic        load_hit;

    // Byte offset bits of the load address never affect the word match.
    logic unused_load_offset;
    assign unused_load_offset = ^LoadAddr[1:0];

    // Decode, alignment and lane formatting of the incoming store.
    always_comb begin
        legal_code = 1'b0;
        aligned    = 1'b0;
        fmt_data   = '0;
        fmt_strb   = '0;
        case (StoreControl)
            CTRL_SB: begin
                legal_code = 1'b1;
                aligned    = 1'b1;
                fmt_data   = {4{StoreData[7:0]}};
                fmt_strb   = 4'b0001 << StoreAddr[1:0];
            end
            CTRL_SH: begin
                legal_code = 1'b1;
                aligned    = ~StoreAddr[0];
                fmt_data   = {2{StoreData[15:0]}};
                fmt_strb   = StoreAddr[1] ? 4'b1100 : 4'b0011;
            end
            CTRL_SW: begin
                legal_code = 1'b1;
                aligned    = (StoreAddr[1:0] == 2'b00);
                fmt_data   = StoreData;
                fmt_strb   = 4'b1111;
            end
            default: begin
                legal_code = 1'b0;
                aligned    = 1'b0;
            end
        endcase
    end

    assign full            = (count_q == cnt_t'(DEPTH));
    assign Empty           = (count_q == '0);
    assign MemWValid       = ~Empty;
    assign MisalignedStore = StoreValid & legal_code & ~aligned;
    // Full rejects even if the head drains this cycle: no pass-through.
    assign StallStore      = StoreValid & legal_code & aligned & full;
    assign enq             = StoreValid & legal_code & aligned & ~full;
    assign deq             = MemWValid & MemWReady;

    assign MemWAddr = {waddr_q[head_q], 2'b00};
    assign MemWData = wdata_q[head_q];
    assign MemWStrb = wstrb_q[head_q];

    // Load hazard: any pending entry, including a head being drained now.
    always_comb begin
        load_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (waddr_q[i] == LoadAddr[31:2])) begin
                load_hit = 1'b1;
            end
        end
    end

    assign StallLoad = LoadValid & load_hit;

    // Next-state for queue storage and pointers.
    always_comb begin
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        vld_d   = vld_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (enq) begin
            waddr_d[tail_q] = StoreAddr[31:2];
            wdata_d[tail_q] = fmt_data;
            wstrb_d[tail_q] = fmt_strb;
            vld_d[tail_q]   = 1'b1;
            tail_d          = tail_q + ptr_t'(1);
        end

        // enq and deq never touch the same slot: enq needs !full, deq needs
        // !empty, so tail==head cannot occur when both fire.
        if (deq) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + ptr_t'(1);
        end

        case ({enq, deq})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= '0;
                wdata_q[i] <= '0;
                wstrb_q[i] <= '0;
            end
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= waddr_d[i];
                wdata_q[i] <= wdata_d[i];
                wstrb_q[i] <= wstrb_d[i];
            end
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: doc/store_write_buffer.md
# store_write_buffer

Sits between the store-data formatter in the MEM stage and the data-memory write port. It accepts zero-extended store data, aligns it onto the 32-bit bus byte lanes, and generates byte strobes. Stores are queued in a small FIFO and drained to memory over a valid/ready handshake. It stalls the pipeline when the queue is full and blocks loads that hit a pending store's word.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- StoreValid  in  1  store instruction present in MEM this cycle
- StoreAddr  in  32  byte address of store
- StoreData  in  32  store data, already zero-extended (byte in [7:0], half in [15:0])
- StoreControl  in  3  000 sb, 001 sh, 010 sw; other codes = no store
- LoadValid  in  1  load instruction present in MEM this cycle
- LoadAddr  in  32  byte address of load
- StallStore  out  1  store cannot be accepted this cycle; pipeline holds MEM
- StallLoad  out  1  load word matches a pending entry; pipeline holds MEM
- MisalignedStore  out  1  store rejected as misaligned
- MemWValid  out  1  head entry presented to memory
- MemWAddr  out  32  word address, [1:0] = 00
- MemWData  out  32  lane-aligned data
- MemWStrb  out  4  byte enables, bit i = lane [8i+7:8i]
- MemWReady  in  1  memory accepts head entry
- Empty  out  1  no pending entries (fence/drain indicator)

## Operation
- Legal store: StoreValid and StoreControl ∈ {000,001,010} and aligned. Illegal codes ignored silently; no flag.
- Alignment: sb always aligned; sh needs StoreAddr[0]=0; sw needs StoreAddr[1:0]=00. Otherwise MisalignedStore=1 (combinational, same cycle), entry not enqueued, StallStore=0.
- Lane mapping, o = StoreAddr[1:0]: sb: data = {4{StoreData[7:0]}}, strb = 0001<<o. sh: data = {2{StoreData[15:0]}}, strb = 0011 (o=00) or 1100 (o=10). sw: data = StoreData, strb = 1111. Stored address = {StoreAddr[31:2],2'b00}.
- Enqueue: legal aligned store and count<DEPTH. Entry = {addr, data, strb}, written at tail, tail++ mod DEPTH.
- StallStore = StoreValid & legal & aligned & (count==DEPTH). Full rejects even if a dequeue occurs same cycle (no pass-through).
- Dequeue: MemWValid & MemWReady; head++ mod DEPTH.
- Simultaneous enqueue+dequeue (count<DEPTH): count unchanged, both pointers advance.
- MemWValid = !Empty; MemWAddr/Data/Strb driven from head entry registers.
- StallLoad = LoadValid & (∃ valid entry with addr[31:2] == LoadAddr[31:2]). Combinational, includes the head entry even when MemWReady=1 that cycle. Store in the same cycle is not compared.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits, range 0..DEPTH.

## Timing
- Reset: head=tail=count=0; MemWValid=0, Empty=1, MemWAddr/Data/Strb=0, StallStore/StallLoad/MisalignedStore=0 (given inputs idle).
- Reset mid-operation: all pending entries discarded; MemWValid=0 from the cycle after the reset edge regardless of MemWReady.
- Latency: store accepted at edge N appears on the bus (MemWValid=1) in cycle N+1 if the FIFO was empty.
- Throughput: one enqueue and one dequeue per cycle.
- Handshake: once MemWValid=1, MemWAddr/Data/Strb and MemWValid hold stable until the edge where MemWReady=1. MemWReady while MemWValid=0 has no effect.
- StallStore, StallLoad, MisalignedStore: combinational from current inputs and state; no registered delay.

## Test plan
- Reset, then sb addr 0x103 data 0x000000A5, MemWReady=1 -> next cycle MemWValid=1, MemWAddr=0x100, MemWData=0xA5A5A5A5, MemWStrb=1000; dequeued; Empty=1 after.
- sh addr 0x202 data 0x0000BEEF, sw addr 0x300 data 0x12345678, MemWReady=1 -> bus sees {0x200, 0xBEEFBEEF, 1100} then {0x300, 0x12345678, 1111} on consecutive cycles.
- MemWReady=0, issue DEPTH+1 sw stores -> first DEPTH accepted, StallStore=1 on the last; raise MemWReady -> entries drain in order, bus stable during wait.
- sh addr 0x401, sw addr 0x402 -> MisalignedStore=1 each cycle, nothing enqueued, Empty stays 1.
- Pending sw to 0x500 with MemWReady=0, lw 0x502 -> StallLoad=1; lw 0x504 -> StallLoad=0; after drain, lw 0x500 -> StallLoad=0.
- Fill 3 entries, assert reset one cycle with MemWReady=0 -> MemWValid=0, Empty=1 next cycle; a subsequent store is the only entry emitted.
